// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-filter frame scheduler.
package edge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLine,
    StGap,
    StFlush,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DRAIN_TIMEOUT = 16;

endpackage

// File: rtl/edge_wr_seq.sv
// Counts filter output samples, drops the leading SKIP, and sequences result-buffer writes.
module edge_wr_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 12,
  parameter int unsigned SKIP  = 4,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             f_de_i,
  input  logic [WIDTH-1:0] f_data_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             last_o,
  output logic             full_o
);

  localparam int unsigned Total = SKIP + N;
  localparam int unsigned CW    = $clog2(Total + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_win;

  always_comb begin
    in_win    = (cnt_q >= CW'(SKIP)) && (cnt_q < CW'(Total));
    wr_en_o   = f_de_i && in_win && !clr_i;
    wr_addr_o = wr_en_o ? AW'(cnt_q - CW'(SKIP)) : '0;
    wr_data_o = wr_en_o ? f_data_i : '0;
    last_o    = wr_en_o && (cnt_q == CW'(Total - 1));
    full_o    = (cnt_q == CW'(Total));
    cnt_d     = cnt_q;
    // Saturate once the frame is written so stray samples cannot wrap back into the window.
    if (clr_i) begin
      cnt_d = '0;
    end else if (f_de_i && !full_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/edge_frame_sched.sv
// Frame scheduler: streams a source frame through an external filter and stores its output.
module edge_frame_sched
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned H_RES = 170,
  parameter int unsigned V_RES = 120,
  parameter int unsigned GAP   = 4,
  parameter int unsigned SKIP  = H_RES,
  localparam int unsigned AW   = $clog2(H_RES * V_RES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_rd_en,
  output logic [AW-1:0]    o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_f_vsync,
  output logic             o_f_hsync,
  output logic             o_f_de,
  output logic [WIDTH-1:0] o_f_data,
  input  logic             i_f_de,
  input  logic [WIDTH-1:0] i_f_data,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data
);

  localparam int unsigned ColW  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned LineW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned ToW   = $clog2(DRAIN_TIMEOUT);

  state_e           state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [LineW-1:0] line_q, line_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             f_de_q, f_de_d, f_hs_q, f_hs_d, f_vs_q, f_vs_d, f_fl_q, f_fl_d;
  logic             rd_en, err, wr_last, wr_full;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    gap_d   = gap_q;
    to_d    = to_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    err     = 1'b0;
    if (i_abort) begin
      state_d = StIdle;
      col_d   = '0;
      line_d  = '0;
      gap_d   = '0;
      to_d    = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          col_d  = '0;
          line_d = '0;
          gap_d  = '0;
          to_d   = '0;
          addr_d = '0;
          if (i_start) state_d = StLine;
        end
        StLine: begin
          rd_en  = 1'b1;
          addr_d = addr_q + AW'(1);
          if (col_q == ColW'(H_RES - 1)) begin
            col_d   = '0;
            gap_d   = '0;
            state_d = StGap;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
        StGap: begin
          if (gap_q == GapW'(GAP - 1)) begin
            gap_d = '0;
            if (line_q == LineW'(V_RES - 1)) begin
              line_d  = '0;
              state_d = StFlush;
            end else begin
              line_d  = line_q + LineW'(1);
              state_d = StLine;
            end
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
        StFlush: begin
          if (col_q == ColW'(H_RES - 1)) begin
            col_d   = '0;
            to_d    = '0;
            state_d = StDrain;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
        StDrain: begin
          // A completed write count also ends the frame if the last write beat us into DRAIN.
          if (wr_last || wr_full) begin
            state_d = StDone;
          end else if (i_f_de) begin
            to_d = '0;
          end else if (to_q == ToW'(DRAIN_TIMEOUT - 1)) begin
            err     = 1'b1;
            to_d    = '0;
            state_d = StIdle;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Filter timing is the read strobe delayed one cycle, lining up with i_rd_data.
  always_comb begin
    f_de_d = !i_abort && ((state_q == StLine) || (state_q == StFlush));
    f_hs_d = f_de_d && (col_q == '0);
    f_vs_d = f_hs_d && (state_q == StLine) && (line_q == '0);
    f_fl_d = !i_abort && (state_q == StFlush);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      col_q   <= '0;
      line_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      addr_q  <= '0;
      f_de_q  <= 1'b0;
      f_hs_q  <= 1'b0;
      f_vs_q  <= 1'b0;
      f_fl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      f_de_q  <= f_de_d;
      f_hs_q  <= f_hs_d;
      f_vs_q  <= f_vs_d;
      f_fl_q  <= f_fl_d;
    end
  end

  edge_wr_seq #(
    .WIDTH (WIDTH),
    .N     (H_RES * V_RES),
    .SKIP  (SKIP),
    .AW    (AW)
  ) u_wr_seq (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     ((state_q == StIdle) || i_abort),
    .f_de_i    (i_f_de),
    .f_data_i  (i_f_data),
    .wr_en_o   (o_wr_en),
    .wr_addr_o (o_wr_addr),
    .wr_data_o (o_wr_data),
    .last_o    (wr_last),
    .full_o    (wr_full)
  );

  always_comb begin
    o_busy    = (state_q != StIdle);
    o_done    = (state_q == StDone) && !i_abort;
    o_err     = err;
    o_rd_en   = rd_en;
    o_rd_addr = rd_en ? addr_q : '0;
    o_f_de    = f_de_q && !i_abort;
    o_f_hsync = f_hs_q && !i_abort;
    o_f_vsync = f_vs_q && !i_abort;
    o_f_data  = (o_f_de && !f_fl_q) ? i_rd_data : '0;
  end

endmodule

// File: tb/tb_edge_frame_sched.sv
// Randomized bench for edge_frame_sched against a cycle-indexed frame timing model.
module tb_edge_frame_sched;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int G  = 4;
  localparam int SK = 4;
  localparam int N  = H * V;
  localparam int AW = 4;
  localparam int P  = H + G;
  localparam int LT = V * P;
  localparam int FE = LT + H;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          o_busy, o_done, o_err, o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [W-1:0]  rd_data = '0;
  logic          o_f_vsync, o_f_hsync, o_f_de;
  logic [W-1:0]  o_f_data;
  logic          i_f_de;
  logic [W-1:0]  i_f_data;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [W-1:0]  o_wr_data;

  logic [W-1:0]  mem [0:15];
  logic [3:0]    dl_de = '0;
  logic [W-1:0]  dl_dat [0:3];
  bit            lb_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  edge_frame_sched #(
    .WIDTH (W),
    .H_RES (H),
    .V_RES (V),
    .GAP   (G),
    .SKIP  (SK)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (rd_data),
    .o_f_vsync (o_f_vsync),
    .o_f_hsync (o_f_hsync),
    .o_f_de    (o_f_de),
    .o_f_data  (o_f_data),
    .i_f_de    (i_f_de),
    .i_f_data  (i_f_data),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data)
  );

  always #5 clk = ~clk;

  // Source frame buffer (1-cycle read latency) and a 4-cycle loopback filter.
  always @(posedge clk) begin
    if (o_rd_en) rd_data <= mem[o_rd_addr];
    dl_de     <= {dl_de[2:0], o_f_de};
    dl_dat[0] <= o_f_data;
    for (int k = 1; k < 4; k++) dl_dat[k] <= dl_dat[k-1];
  end

  assign i_f_de   = lb_en & dl_de[3];
  assign i_f_data = dl_dat[3] ^ 8'h5A;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_f_vsync, o_f_hsync, o_f_de, o_f_data,
         o_wr_en, o_wr_addr, o_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b rd_en=%b f_de=%b wr_en=%b, required all 0",
               o_busy, o_rd_en, o_f_de, o_wr_en);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: got busy=%b rd_en=%b, required 0 0", o_busy, o_rd_en);
      end
    end
  endtask

  // Runs one frame from a start pulse; abort_t/restart_t < 0 disables those events.
  task automatic test_frame_run(input string name, input bit lb, input int abort_t,
                                input int restart_t);
    int n, end_t, tp, e_addr, e_wa, hs_c, vs_c, done_c, err_c;
    bit e_rd, e_fde, e_hs, e_vs, e_wr, e_busy, e_done, e_err;
    logic [W-1:0] e_fdata, e_wdata;
    logic [AW-1:0] e_wa_v, e_addr_v;
    lb_en = lb;
    for (int i = 0; i < 16; i++) mem[i] = W'($urandom);
    n = 0; hs_c = 0; vs_c = 0; done_c = 0; err_c = 0;
    end_t = lb ? FE + 5 : FE + 15;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int t = 0; t < end_t + 4; t++) begin
      i_abort = (t == abort_t);
      i_start = (t == restart_t);
      #1;
      tp      = t - 1;
      e_rd    = (t < LT) && ((t % P) < H);
      e_addr  = (t / P) * H + (t % P);
      e_fde   = (t >= 1) && (((tp < LT) && ((tp % P) < H)) || ((tp >= LT) && (tp < FE)));
      e_hs    = e_fde && ((tp % P) == 0);
      e_vs    = e_fde && (tp == 0);
      e_fdata = '0;
      if (e_fde && tp < LT) e_fdata = mem[(tp / P) * H + (tp % P)];
      e_busy  = (t <= end_t);
      e_done  = lb && (t == end_t);
      e_err   = !lb && (t == end_t);
      e_wr    = i_f_de && (n >= SK) && (n < SK + N) && e_busy;
      e_wa    = n - SK;
      e_wdata = 8'h5A;
      if (n < N) e_wdata = mem[n] ^ 8'h5A;
      if (abort_t >= 0 && t >= abort_t) begin
        e_rd = 0; e_fde = 0; e_hs = 0; e_vs = 0; e_wr = 0; e_done = 0; e_err = 0;
        e_busy = (t == abort_t);
      end
      e_wa_v   = e_wa[AW-1:0];
      e_addr_v = e_addr[AW-1:0];
      checks += 5;
      if (o_rd_en !== e_rd || (e_rd && o_rd_addr !== e_addr_v)) begin
        failures++;
        $display("FAIL %s rd t=%0d: got en=%b addr=%0d, required en=%b addr=%0d",
                 name, t, o_rd_en, o_rd_addr, e_rd, e_addr_v);
      end
      if (o_f_de !== e_fde || (e_fde && o_f_data !== e_fdata)) begin
        failures++;
        $display("FAIL %s f_de t=%0d: got de=%b data=%h, required de=%b data=%h",
                 name, t, o_f_de, o_f_data, e_fde, e_fdata);
      end
      if (o_f_hsync !== e_hs || o_f_vsync !== e_vs) begin
        failures++;
        $display("FAIL %s sync t=%0d: got hs=%b vs=%b, required hs=%b vs=%b",
                 name, t, o_f_hsync, o_f_vsync, e_hs, e_vs);
      end
      if (o_wr_en !== e_wr || (e_wr && (o_wr_addr !== e_wa_v || o_wr_data !== e_wdata))) begin
        failures++;
        $display("FAIL %s wr t=%0d: got en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                 name, t, o_wr_en, o_wr_addr, o_wr_data, e_wr, e_wa_v, e_wdata);
      end
      if (o_busy !== e_busy || o_done !== e_done || o_err !== e_err) begin
        failures++;
        $display("FAIL %s ctl t=%0d: got busy=%b done=%b err=%b, required %b %b %b",
                 name, t, o_busy, o_done, o_err, e_busy, e_done, e_err);
      end
      if (o_f_hsync === 1'b1) hs_c++;
      if (o_f_vsync === 1'b1) vs_c++;
      if (o_done === 1'b1) done_c++;
      if (o_err === 1'b1) err_c++;
      if (i_f_de) n++;
      @(posedge clk);
      #1;
    end
    i_abort = 1'b0;
    i_start = 1'b0;
    if (abort_t < 0) begin
      checks++;
      if (hs_c != V + 1 || vs_c != 1 || done_c != int'(lb) || err_c != int'(!lb)) begin
        failures++;
        $display("FAIL %s totals: got hs=%0d vs=%0d done=%0d err=%0d, required %0d 1 %0d %0d",
                 name, hs_c, vs_c, done_c, err_c, V + 1, int'(lb), int'(!lb));
      end
    end else begin
      checks++;
      if (done_c != 0 || err_c != 0) begin
        failures++;
        $display("FAIL %s abort_pulses: got done=%0d err=%0d, required 0 0",
                 name, done_c, err_c);
      end
    end
  endtask

  task automatic test_frame();
    test_frame_run("frame", 1'b1, -1, -1);
  endtask

  task automatic test_back_to_back();
    test_frame_run("b2b_a", 1'b1, -1, -1);
    test_frame_run("b2b_b", 1'b1, -1, -1);
  endtask

  task automatic test_restart_ignored();
    test_frame_run("restart", 1'b1, -1, 12);
  endtask

  task automatic test_abort();
    test_frame_run("abort", 1'b1, 1 * P + 2, -1);
    test_frame_run("after_abort", 1'b1, -1, -1);
  endtask

  task automatic test_timeout();
    test_frame_run("timeout", 1'b0, -1, -1);
  endtask

  task automatic test_reset_gap();
    lb_en = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (o_f_de !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_pre: got f_de=%b busy=%b, required 1 1", o_f_de, o_busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_f_vsync, o_f_hsync, o_f_de, o_f_data,
         o_wr_en, o_wr_addr, o_wr_data} !== '0) begin
      failures++;
      $display("FAIL gap_reset_outputs: got busy=%b f_de=%b f_data=%h, required all 0",
               o_busy, o_f_de, o_f_data);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_f_de !== 1'b0 || o_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL gap_no_resume: got busy=%b rd_en=%b f_de=%b wr_en=%b, required 0",
                 o_busy, o_rd_en, o_f_de, o_wr_en);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) dl_dat[k] = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_restart_ignored();
    test_abort();
    test_timeout();
    test_reset_gap();
    test_frame_run("post_reset", 1'b1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_frame_sched.md
EDGE_FRAME_SCHED -- requirements
Module: edge_frame_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel width.
REQ-002 SHALL have parameter H_RES, default 170: pixels per line.
REQ-003 SHALL have parameter V_RES, default 120: lines per frame.
REQ-004 SHALL have parameter GAP, default 4: idle cycles between lines (min 4).
REQ-005 SHALL have parameter SKIP, default H_RES: leading filter output samples to discard.
REQ-006 SHALL have AW = clog2(H_RES*V_RES) as a derived local constant.
REQ-007 SHALL have ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  pulse; begin frame
- i_abort  in  1  level; cancel frame
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle drain-timeout pulse
- o_rd_en  out  1  source frame-buffer read strobe
- o_rd_addr  out  AW  source address
- i_rd_data  in  WIDTH  data, valid 1 cycle after o_rd_en
- o_f_vsync, o_f_hsync, o_f_de  out  1 each  filter input timing
- o_f_data  out  WIDTH  filter input pixel
- i_f_de  in  1  filter output valid
- i_f_data  in  WIDTH  filter output pixel
- o_wr_en  out  1  result-buffer write strobe
- o_wr_addr  out  AW  result address
- o_wr_data  out  WIDTH  result pixel

Function
REQ-008 SHALL implement FSM IDLE, LINE, GAP, FLUSH, DRAIN, DONE.
REQ-009 SHALL leave IDLE for LINE only on i_start=1 with i_abort=0; i_start SHALL be ignored in all other states.
REQ-010 In LINE, SHALL assert o_rd_en for H_RES consecutive cycles, with o_rd_addr = line*H_RES + col and address incrementing by 1.
REQ-011 SHALL drive o_f_de/o_f_data from o_rd_en/i_rd_data registered by exactly 1 cycle, so each line is a contiguous H_RES-cycle de burst.
REQ-012 SHALL raise o_f_hsync with the first de cycle of each line (FLUSH included), and o_f_vsync only with the first de cycle of line 0; both SHALL be low otherwise.
REQ-013 After each line, SHALL enter GAP for exactly GAP cycles with o_f_de=0, then go to LINE, or to FLUSH after line V_RES-1.
REQ-014 In FLUSH, SHALL drive one line of H_RES de cycles with o_f_data=0 and o_rd_en=0, then enter DRAIN.
REQ-015 SHALL count i_f_de samples in every non-IDLE state, discard the first SKIP, then write the next H_RES*V_RES with o_wr_en=1, o_wr_data=i_f_data, and o_wr_addr from 0 incrementing by 1, in the same cycle as i_f_de (combinational from the counter, registered data path allowed).
REQ-016 SHALL never issue writes beyond address H_RES*V_RES-1; extra i_f_de samples SHALL be ignored.
REQ-017 SHALL go from DRAIN to DONE on the cycle the final write is issued.
REQ-018 SHALL pulse o_err, skip o_done, and go to IDLE if DRAIN sees no i_f_de for 16 consecutive cycles.
REQ-019 DONE SHALL last 1 cycle with o_done=1, then go to IDLE.
REQ-020 o_busy SHALL be 1 in every state except IDLE.
REQ-021 i_abort=1 in any state SHALL force IDLE on the next edge, drop o_rd_en/o_f_de/o_wr_en that cycle, clear all counters, and produce no o_done/o_err.
REQ-022 Counters SHALL wrap exactly at terminal counts (col at H_RES-1, line at V_RES-1) with no off-by-one.

Reset
REQ-023 rstn=0 SHALL asynchronously force IDLE and drive every output to 0, with all counters 0.
REQ-024 Reset deasserted mid-frame SHALL resume only on a new i_start.

Structure
REQ-025 The FSM state enum and the DRAIN_TIMEOUT=16 constant SHALL live in shared package edge_pkg.
REQ-026 The sample skip/write counter SHALL be a sub-module, edge_wr_seq.
REQ-027 SHALL contain no pixel arithmetic; the filter stays external.

Verification (H_RES=4, V_RES=3, GAP=4, SKIP=4)
REQ-028 Start on an idle block -> rd_addr 0..11 in three 4-cycle bursts separated by 4 idle cycles, then a 4-cycle zero flush line, vsync once, hsync 4 times.
REQ-029 Loopback model feeding i_f_de = o_f_de delayed 4 cycles -> samples 0-3 discarded, wr_addr 0..11 written, o_done a single pulse, o_busy low the cycle after.
REQ-030 i_abort during line 1, col 2 -> next cycle IDLE, no further rd/wr strobes, no o_done; a later i_start runs a full clean frame.
REQ-031 i_f_de held low in DRAIN -> o_err pulses after 16 cycles, no o_done, IDLE.
REQ-032 i_start pulsed again while busy -> ignored, addresses unperturbed.
REQ-033 rstn asserted in GAP -> all outputs 0 immediately, IDLE after release.
